ofm_postproc_writer: RTL and testbench

- Downstream consumer of the conv core's 16-bit output psum stream (one pixel per beat, after all channels are accumulated).
- Per pixel: adds bias, applies optional ReLU, requantizes to signed 8-bit with rounding and saturation.
- Packs 4 pixels per 32-bit word, generates OFM memory write addresses, and signals frame completion.

---
 rtl/ofm_postproc_writer_pkg.sv | 20 ++
 rtl/ofm_postproc_writer_if.sv | 26 ++
 rtl/ofm_postproc_writer_requant_unit.sv | 66 ++++++
 rtl/ofm_postproc_writer.sv | 154 +++++++++++++++
 tb/tb_ofm_postproc_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_postproc_writer_pkg.sv
// Shared constants and FSM encoding for the OFM post-processing writer.
// Widths here are the defaults; the modules carry them as overridable parameters.
package ofm_postproc_writer_pkg;

    localparam int DATA_W  = 16;
    localparam int OUT_W   = 8;
    localparam int PACK_N  = 4;
    localparam int WORD_W  = PACK_N * OUT_W;
    localparam int SHIFT_W = 4;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ofm_postproc_writer_if.sv
// Psum input stream and OFM memory write port of the post-processing writer.
// Both channels use valid/ready: a beat transfers on a rising clk1 edge where valid && ready
// are both high; once raised, valid and its payload stay stable until that transfer.
interface ofm_postproc_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;

    // master: the writer block; slave: the psum producer plus the OFM memory
    modport master (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
    modport slave (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/ofm_postproc_writer_requant_unit.sv
// Per-pixel arithmetic: registered bias add (S1), then ReLU, round-half-up shift and
// saturation to a signed byte (S2), which the packer captures directly.
module ofm_postproc_writer_requant_unit
    import ofm_postproc_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int OUT_WIDTH  = OUT_W
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  relu,
    output logic                  q_valid,
    output logic [OUT_WIDTH-1:0]  q_byte
);

    localparam int SUM_W = DATA_WIDTH + 1;
    // Two guard bits: the rounding increment can push a full-scale sum past SUM_W.
    localparam int EXT_W = DATA_WIDTH + 2;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(SAT_MAX);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(SAT_MIN);

    logic                    s1_valid;
    logic signed [SUM_W-1:0] s1_sum;
    logic signed [EXT_W-1:0] relu_v;
    logic signed [EXT_W-1:0] round_inc;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum <= $signed({in_data[DATA_WIDTH-1], in_data}) +
                          $signed({bias[DATA_WIDTH-1], bias});
            end
        end
    end

    always_comb begin
        relu_v = {s1_sum[SUM_W-1], s1_sum};
        if (relu && relu_v[EXT_W-1]) begin
            relu_v = '0;
        end
        round_inc = (shift == '0) ? '0 : (EXT_W'(1) << (shift - SHIFT_W'(1)));
        rounded   = relu_v + round_inc;
        shifted   = rounded >>> shift;
        if (shifted > SAT_HI) begin
            q_byte = OUT_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_LO) begin
            q_byte = OUT_WIDTH'(SAT_MIN);
        end else begin
            q_byte = shifted[OUT_WIDTH-1:0];
        end
    end

    assign q_valid = s1_valid;

endmodule

// File: rtl/ofm_postproc_writer.sv
// OFM post-processing writer: requantizes a frame of psums, packs PACK bytes per word and
// writes them to sequential OFM addresses, pulsing done after the last word is accepted.
module ofm_postproc_writer
    import ofm_postproc_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int OUT_WIDTH  = OUT_W,
    parameter int PACK       = PACK_N,
    parameter int OFM_SIZE   = 62,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_bias,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic                  cfg_relu,
    ofm_postproc_writer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int FRAME      = OFM_SIZE * OFM_SIZE;
    localparam int WORDS      = (FRAME + PACK - 1) / PACK;
    localparam int CNT_W      = $clog2(FRAME + 1);
    localparam int SLOT_W     = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_WIDTH = PACK * OUT_WIDTH;
    localparam logic [CNT_W-1:0]      LAST_PIX  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0]      FRAME_CNT = CNT_W'(FRAME);
    localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(PACK - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    state_e                  state, state_next;
    logic [DATA_WIDTH-1:0]   bias_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic                    relu_q;
    logic [CNT_W-1:0]        in_cnt;
    logic [CNT_W-1:0]        out_cnt;
    logic [SLOT_W-1:0]       slot;
    logic [WORD_WIDTH-1:0]   pack_buf;
    logic [WORD_WIDTH-1:0]   merged;
    logic                    wr_valid_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [WORD_WIDTH-1:0]   wr_data_q;
    logic                    en, in_ready, accept, take_start;
    logic                    q_valid, load;
    logic [OUT_WIDTH-1:0]    q_byte;

    // Every stage moves together; a stalled output word freezes the whole pipe.
    assign en         = !wr_valid_q || bus.wr_ready;
    assign in_ready   = en && (state == ST_RUN) && (in_cnt < FRAME_CNT);
    assign accept     = bus.in_valid && in_ready;
    assign take_start = (state == ST_IDLE) && start;
    assign load       = en && q_valid && ((slot == LAST_SLOT) || (out_cnt == LAST_PIX));

    ofm_postproc_writer_requant_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant_unit (
        .clk1    (clk1),
        .rst     (rst),
        .en      (en),
        .in_valid(accept),
        .in_data (bus.in_data),
        .bias    (bias_q),
        .shift   (shift_q),
        .relu    (relu_q),
        .q_valid (q_valid),
        .q_byte  (q_byte)
    );

    always_comb begin
        merged = pack_buf;
        for (int k = 0; k < PACK; k++) begin
            if (slot == SLOT_W'(k)) begin
                merged[k*OUT_WIDTH +: OUT_WIDTH] = q_byte;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (accept && (in_cnt == LAST_PIX)) state_next = ST_FLUSH;
            // Leave only once every pixel is packed and the final word is handing off.
            ST_FLUSH: if ((out_cnt == FRAME_CNT) && (!wr_valid_q || bus.wr_ready)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bias_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            slot       <= '0;
            pack_buf   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state <= state_next;
            if (take_start) begin
                bias_q    <= cfg_bias;
                shift_q   <= cfg_shift;
                relu_q    <= cfg_relu;
                in_cnt    <= '0;
                out_cnt   <= '0;
                slot      <= '0;
                pack_buf  <= '0;
                wr_addr_q <= '0;
            end else begin
                if (accept) begin
                    in_cnt <= in_cnt + 1'b1;
                end
                if (en && q_valid) begin
                    out_cnt <= out_cnt + 1'b1;
                    if (load) begin
                        slot      <= '0;
                        pack_buf  <= '0;
                        wr_data_q <= merged;
                    end else begin
                        slot     <= slot + 1'b1;
                        pack_buf <= merged;
                    end
                end
                // The final word keeps its address so wr_addr never runs past the frame.
                if (wr_valid_q && bus.wr_ready && (wr_addr_q != LAST_ADDR)) begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                end
                if (load) begin
                    wr_valid_q <= 1'b1;
                end else if (bus.wr_ready) begin
                    wr_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state == ST_RUN) || (state == ST_FLUSH);
    assign done         = (state == ST_DONE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_ofm_postproc_writer.sv
// Bench for ofm_postproc_writer: a 4x4-frame instance and a 3x3-frame instance share the
// clock, stimulus and monitor; sel picks which one is exercised.
module tb_ofm_postproc_writer;
  import ofm_postproc_writer_pkg::*;

  typedef struct packed {
    logic [15:0]      bias;
    logic [3:0]       shift;
    logic             relu;
    logic [3:0][15:0] px;
    logic [31:0]      exp_word;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;
  int cyc_cnt = 0;
  always @(posedge clk1) cyc_cnt <= cyc_cnt + 1;

  // ---------------- stimulus signals ----------------
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_bias = '0;
  logic [3:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        wr_ready = 1'b1;
  logic        bp_mode = 1'b0;

  logic   busy4, done4, busy3, done3;
  state_e dbg4, dbg3;

  ofm_postproc_writer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WORD_WIDTH(32)) bus4 ();
  ofm_postproc_writer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .WORD_WIDTH(32)) bus3 ();

  assign bus4.in_valid = in_valid && !sel;
  assign bus4.in_data  = in_data;
  assign bus4.wr_ready = wr_ready;
  assign bus3.in_valid = in_valid && sel;
  assign bus3.in_data  = in_data;
  assign bus3.wr_ready = wr_ready;

  ofm_postproc_writer #(.OFM_SIZE(4)) dut4 (
    .clk1(clk1), .rst(rst), .start(start && !sel),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bus(bus4), .busy(busy4), .done(done4), .dbg_state(dbg4)
  );

  ofm_postproc_writer #(.OFM_SIZE(3)) dut3 (
    .clk1(clk1), .rst(rst), .start(start && sel),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bus(bus3), .busy(busy3), .done(done3), .dbg_state(dbg3)
  );

  logic        in_ready_m, wr_valid_m, busy_m, done_m;
  logic [9:0]  wr_addr_m;
  logic [31:0] wr_data_m;
  assign in_ready_m = sel ? bus3.in_ready : bus4.in_ready;
  assign wr_valid_m = sel ? bus3.wr_valid : bus4.wr_valid;
  assign wr_addr_m  = sel ? bus3.wr_addr  : bus4.wr_addr;
  assign wr_data_m  = sel ? bus3.wr_data  : bus4.wr_data;
  assign busy_m     = sel ? busy3 : busy4;
  assign done_m     = sel ? done3 : done4;

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  string       cur_tag = "reset";
  logic        sb_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [15:0] pix_q[$];
  int          last_hs_cyc = 0;
  int          done_cnt = 0;
  logic        stalled = 1'b0;
  logic [31:0] stall_data;
  logic [9:0]  stall_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", cur_tag, name, act, exp);
    end
  endtask

  task automatic push_word(input logic [9:0] addr, input logic [31:0] word);
    exp_addr_q.push_back(addr);
    exp_q.push_back(word);
  endtask

  always @(negedge clk1) begin
    if (done4 || done3) done_cnt++;
    if (stalled && !rst) begin
      check("stall_valid", {31'd0, wr_valid_m}, 32'd1);
      check("stall_data", wr_data_m, stall_data);
      check("stall_addr", {22'd0, wr_addr_m}, {22'd0, stall_addr});
    end
    stalled    = wr_valid_m && !wr_ready && !rst;
    stall_data = wr_data_m;
    stall_addr = wr_addr_m;
    if (wr_valid_m && wr_ready && !rst) begin
      last_hs_cyc = cyc_cnt;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s.extra_word: got 0x%08h at addr %0d, expected no word", cur_tag, wr_data_m, wr_addr_m);
        end else begin
          check("wr_data", wr_data_m, exp_q.pop_front());
          check("wr_addr", {22'd0, wr_addr_m}, {22'd0, exp_addr_q.pop_front()});
        end
      end
    end
  end

  // Random memory backpressure; stays high unless bp_mode is set.
  always @(posedge clk1) begin
    #1;
    wr_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Ends at posedge+1 with the frame armed and the input cfg scrambled.
  task automatic pulse_start(input logic [15:0] bias, input logic [3:0] shift, input logic relu);
    @(posedge clk1); #1;
    cfg_bias  = bias;
    cfg_shift = shift;
    cfg_relu  = relu;
    start     = 1'b1;
    @(posedge clk1); #1;
    start     = 1'b0;
    cfg_bias  = 16'(~bias);
    cfg_shift = 4'(~shift);
    cfg_relu  = ~relu;
    check("busy_after_start", {31'd0, busy_m}, 32'd1);
    check("addr_after_start", {22'd0, wr_addr_m}, 32'd0);
  endtask

  // Entered at posedge+1; drives pix_q beats honouring in_ready.
  task automatic send_pixels(input int max_cyc);
    int   c;
    logic acc;
    c = 0;
    while (pix_q.size() != 0 && c < max_cyc) begin
      in_valid = 1'b1;
      in_data  = pix_q[0];
      @(negedge clk1);
      acc = in_ready_m;
      @(posedge clk1); #1;
      if (acc) void'(pix_q.pop_front());
      c++;
    end
    in_valid = 1'b0;
    check("send_leftover", 32'(pix_q.size()), 32'd0);
    pix_q.delete();
  endtask

  task automatic wait_done(input int max_cyc);
    int   c;
    logic seen;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < max_cyc) begin
      @(negedge clk1);
      if (done_m) seen = 1'b1;
      c++;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("done_latency", 32'(cyc_cnt - last_hs_cyc), 32'd1);
      check("busy_at_done", {31'd0, busy_m}, 32'd0);
      @(negedge clk1);
      check("done_width", {31'd0, done_m}, 32'd0);
    end
    check("words_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  function automatic vec_t mk(input int b, input int s, input int r,
                              input int p0, input int p1, input int p2, input int p3,
                              input logic [31:0] e);
    vec_t v;
    v.bias     = 16'(b);
    v.shift    = 4'(s);
    v.relu     = 1'(r);
    v.px[0]    = 16'(p0);
    v.px[1]    = 16'(p1);
    v.px[2]    = 16'(p2);
    v.px[3]    = 16'(p3);
    v.exp_word = e;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t        vecs[8];
    vec_t        v;
    int          px;
    logic [31:0] word;
    int          done_before;

    vecs[0] = mk(-10,    2, 1,     30,     10,    -50,   1000, 32'h7F000005);
    vecs[1] = mk(0,      1, 0,     -3,     -4,    255,   -300, 32'h807FFEFF);
    vecs[2] = mk(0,      0, 0,    127,    128,   -128,   -129, 32'h80807F7F);
    vecs[3] = mk(100,    0, 1,   -200,   -100,   -101,     27, 32'h7F000000);
    vecs[4] = mk(0,     15, 0,  32767, -32768,  16384,  16383, 32'h0001FF01);
    vecs[5] = mk(32767,  8, 0,  32767, -32768, -32640, -32767, 32'h0000007F);
    vecs[6] = mk(-32768, 4, 0, -32768,  32767,      0,  31000, 32'h92800080);
    vecs[7] = mk(0,      1, 0,      1,     -1,      3,     -5, 32'hFE020001);

    // Reset values on both instances
    repeat (2) @(negedge clk1);
    check("rst_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    check("rst_wr_valid", {31'd0, bus4.wr_valid}, 32'd0);
    check("rst_wr_addr", {22'd0, bus4.wr_addr}, 32'd0);
    check("rst_wr_data", bus4.wr_data, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_state4", 32'(dbg4), 32'(ST_IDLE));
    check("rst_state3", 32'(dbg3), 32'(ST_IDLE));
    @(posedge clk1); #1;
    rst = 1'b0;

    // Basic frame; in_valid while idle must not be consumed, start while busy is ignored
    cur_tag  = "basic";
    in_valid = 1'b1;
    in_data  = 16'h0055;
    repeat (3) begin
      @(negedge clk1);
      check("idle_in_ready", {31'd0, in_ready_m}, 32'd0);
    end
    in_valid = 1'b0;
    push_word(10'd0, 32'h03020100);
    push_word(10'd1, 32'h07060504);
    push_word(10'd2, 32'h0B0A0908);
    push_word(10'd3, 32'h0F0E0D0C);
    for (int i = 0; i < 8; i++) pix_q.push_back(16'(i));
    pulse_start(16'd0, 4'd0, 1'b0);
    send_pixels(100);
    cfg_bias  = 16'd50;
    cfg_shift = 4'd3;
    cfg_relu  = 1'b1;
    start     = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    check("busy_ignored_start", {31'd0, busy_m}, 32'd1);
    for (int i = 8; i < 16; i++) pix_q.push_back(16'(i));
    send_pixels(100);
    wait_done(100);

    // Table-driven quantization vectors: each 4-pixel group repeated over a 16-pixel frame
    for (int i = 0; i < 8; i++) begin
      v       = vecs[i];
      cur_tag = $sformatf("vec%0d", i);
      for (int w = 0; w < 4; w++) begin
        push_word(10'(w), v.exp_word);
        for (int k = 0; k < 4; k++) pix_q.push_back(v.px[k]);
      end
      pulse_start(v.bias, v.shift, v.relu);
      send_pixels(200);
      wait_done(100);
    end

    // Partial final word on the 3x3 instance
    cur_tag = "partial";
    sel     = 1'b1;
    push_word(10'd0, 32'h04030201);
    push_word(10'd1, 32'h08070605);
    push_word(10'd2, 32'h00000009);
    for (int i = 1; i <= 9; i++) pix_q.push_back(16'(i));
    pulse_start(16'd0, 4'd0, 1'b0);
    send_pixels(100);
    wait_done(100);
    sel = 1'b0;

    // Backpressure: random wr_ready, byte-range pixels pass through unchanged
    bp_mode = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cur_tag = $sformatf("bp%0d", f);
      for (int w = 0; w < 4; w++) begin
        word = '0;
        for (int k = 0; k < 4; k++) begin
          px = int'($urandom_range(0, 255)) - 128;
          pix_q.push_back(16'(px));
          word[k*8 +: 8] = 8'(px);
        end
        push_word(10'(w), word);
      end
      pulse_start(16'd0, 4'd0, 1'b0);
      send_pixels(300);
      wait_done(300);
    end
    bp_mode = 1'b0;

    // Reset after 5 beats aborts the frame silently; the next frame starts clean
    cur_tag = "abort";
    sb_en   = 1'b0;
    for (int i = 0; i < 5; i++) pix_q.push_back(16'(20 + i));
    pulse_start(16'd0, 4'd0, 1'b0);
    send_pixels(50);
    repeat (3) @(posedge clk1);
    #1;
    done_before = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, bus4.in_ready}, 32'd0);
    check("abort_wr_valid", {31'd0, bus4.wr_valid}, 32'd0);
    check("abort_wr_addr", {22'd0, bus4.wr_addr}, 32'd0);
    check("abort_wr_data", bus4.wr_data, 32'd0);
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_state", 32'(dbg4), 32'(ST_IDLE));
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (3) @(negedge clk1);
    check("abort_no_done", 32'(done_cnt), 32'(done_before));
    sb_en   = 1'b1;
    cur_tag = "after_abort";
    push_word(10'd0, 32'h67666564);
    push_word(10'd1, 32'h6B6A6968);
    push_word(10'd2, 32'h6F6E6D6C);
    push_word(10'd3, 32'h73727170);
    for (int i = 0; i < 16; i++) pix_q.push_back(16'(100 + i));
    pulse_start(16'd0, 4'd0, 1'b0);
    send_pixels(100);
    wait_done(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
